// File: rtl/down_counter_timer.sv
// Loadable down-counter with start/busy/done handshake and optional auto-reload.
// Terminal count is 1 (not 0), so the decrement never wraps while running.
module down_counter_timer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] load_val,
   input  logic             count_en,
   input  logic             abort,
   input  logic             auto_reload,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done,
   output logic             zero
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [WIDTH-1:0] CNT_ZERO = '0;
   localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] reload_reg;
   logic [WIDTH-1:0] reload_nxt;
   logic [WIDTH-1:0] count_nxt;
   logic             done_nxt;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state, next-count and done decode; priority abort > start > count_en
   always_comb begin
      state_nxt  = state;
      count_nxt  = count;
      reload_nxt = reload_reg;
      done_nxt   = 1'b0;
      if (abort) begin
         // count and budget freeze where they are
         state_nxt = IDLE;
      end else if (start) begin
         count_nxt = load_val;
         if (load_val == CNT_ZERO) begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
            if (state == RUN) begin
               reload_nxt = load_val;
            end else begin
               reload_nxt = reload_reg;
            end
         end else begin
            reload_nxt = load_val;
            state_nxt  = RUN;
         end
      end else begin
         case (state)
            RUN: begin
               if (count_en) begin
                  if (count == CNT_ONE) begin
                     done_nxt = 1'b1;
                     if (auto_reload) begin
                        count_nxt = reload_reg;
                     end else begin
                        count_nxt = CNT_ZERO;
                        state_nxt = IDLE;
                     end
                  end else begin
                     count_nxt = count - CNT_ONE;
                  end
               end else begin
                  count_nxt = count;
               end
            end
            IDLE: begin
               count_nxt = count;
            end
            default: begin
               state_nxt = IDLE;
            end
         endcase
      end
   end

   // Datapath and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count      <= CNT_ZERO;
         reload_reg <= CNT_ZERO;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         count      <= count_nxt;
         reload_reg <= reload_nxt;
         busy       <= (state_nxt == RUN);
         done       <= done_nxt;
      end
   end

   assign zero = (count == CNT_ZERO);

endmodule

// File: tb/tb_down_counter_timer.sv
// Scoreboard bench for down_counter_timer: each driven cycle pushes its expected
// outputs, which are popped and compared one time unit after the clock edge.
module tb_down_counter_timer;

   localparam int WIDTH = 4;

   logic             clk;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] load_val;
   logic             count_en;
   logic             abort;
   logic             auto_reload;
   logic [WIDTH-1:0] count;
   logic             busy;
   logic             done;
   logic             zero;

   typedef struct {
      int exp_count;
      int exp_busy;
      int exp_done;
   } exp_t;

   exp_t sb[$];
   int   n_checks;
   int   n_fail;

   down_counter_timer #(.WIDTH(WIDTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .load_val    (load_val),
      .count_en    (count_en),
      .abort       (abort),
      .auto_reload (auto_reload),
      .count       (count),
      .busy        (busy),
      .done        (done),
      .zero        (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string tag, input int ec, input int eb, input int ed);
      check({tag, ".count"}, int'(count), ec);
      check({tag, ".busy"},  int'(busy),  eb);
      check({tag, ".done"},  int'(done),  ed);
      check({tag, ".zero"},  int'(zero),  (ec == 0) ? 1 : 0);
   endtask

   // Drive one cycle of inputs, push the expected post-edge outputs, then pop and compare.
   task automatic step(input string tag, input logic st, input int lv, input logic en,
                       input logic ab, input logic ar, input int ec, input int eb, input int ed);
      exp_t e;
      exp_t got;
      @(negedge clk);
      start       = st;
      load_val    = WIDTH'(lv);
      count_en    = en;
      abort       = ab;
      auto_reload = ar;
      e.exp_count = ec;
      e.exp_busy  = eb;
      e.exp_done  = ed;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         check({tag, ".sb_empty"}, 1, 0);
      end else begin
         got = sb.pop_front();
         check_outputs(tag, got.exp_count, got.exp_busy, got.exp_done);
      end
   endtask

   initial begin
      n_checks    = 0;
      n_fail      = 0;
      rst         = 1'b1;
      start       = 1'b0;
      load_val    = '0;
      count_en    = 1'b0;
      abort       = 1'b0;
      auto_reload = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_outputs("reset", 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;

      // 1: load 5, count down to done
      step("t1.load", 1'b1, 5, 1'b1, 1'b0, 1'b0, 5, 1, 0);
      for (int i = 4; i >= 1; i--) begin
         step("t1.dec", 1'b0, 0, 1'b1, 1'b0, 1'b0, i, 1, 0);
      end
      step("t1.tc",   1'b0, 0, 1'b1, 1'b0, 1'b0, 0, 0, 1);
      step("t1.idle", 1'b0, 0, 1'b1, 1'b0, 1'b0, 0, 0, 0);

      // 2: load 3 with count_en toggling
      step("t2.load", 1'b1, 3, 1'b0, 1'b0, 1'b0, 3, 1, 0);
      step("t2.h3",   1'b0, 0, 1'b0, 1'b0, 1'b0, 3, 1, 0);
      step("t2.d2",   1'b0, 0, 1'b1, 1'b0, 1'b0, 2, 1, 0);
      step("t2.h2",   1'b0, 0, 1'b0, 1'b0, 1'b0, 2, 1, 0);
      step("t2.d1",   1'b0, 0, 1'b1, 1'b0, 1'b0, 1, 1, 0);
      step("t2.h1",   1'b0, 0, 1'b0, 1'b0, 1'b0, 1, 1, 0);
      step("t2.tc",   1'b0, 0, 1'b1, 1'b0, 1'b0, 0, 0, 1);

      // 3: auto-reload period 3, then abort freezes the count
      step("t3.load", 1'b1, 3, 1'b1, 1'b0, 1'b1, 3, 1, 0);
      for (int p = 0; p < 3; p++) begin
         step("t3.d2", 1'b0, 0, 1'b1, 1'b0, 1'b1, 2, 1, 0);
         step("t3.d1", 1'b0, 0, 1'b1, 1'b0, 1'b1, 1, 1, 0);
         step("t3.rl", 1'b0, 0, 1'b1, 1'b0, 1'b1, 3, 1, 1);
      end
      step("t3.d2b",  1'b0, 0, 1'b1, 1'b0, 1'b0, 2, 1, 0);
      step("t3.abrt", 1'b0, 0, 1'b1, 1'b1, 1'b0, 2, 0, 0);

      // 4: load 15, restart with 2 at count 7; then a full 15-cycle run
      step("t4.load", 1'b1, 15, 1'b1, 1'b0, 1'b0, 15, 1, 0);
      for (int i = 14; i >= 7; i--) begin
         step("t4.dec", 1'b0, 0, 1'b1, 1'b0, 1'b0, i, 1, 0);
      end
      step("t4.rest", 1'b1, 2, 1'b1, 1'b0, 1'b0, 2, 1, 0);
      step("t4.d1",   1'b0, 0, 1'b1, 1'b0, 1'b0, 1, 1, 0);
      step("t4.tc",   1'b0, 0, 1'b1, 1'b0, 1'b0, 0, 0, 1);
      step("t4.full", 1'b1, 15, 1'b1, 1'b0, 1'b0, 15, 1, 0);
      for (int i = 14; i >= 1; i--) begin
         step("t4.fdec", 1'b0, 0, 1'b1, 1'b0, 1'b0, i, 1, 0);
      end
      step("t4.ftc",  1'b0, 0, 1'b1, 1'b0, 1'b0, 0, 0, 1);

      // 5: abort+start together at count 4, then zero-length start
      step("t5.load", 1'b1, 9, 1'b1, 1'b0, 1'b0, 9, 1, 0);
      for (int i = 8; i >= 4; i--) begin
         step("t5.dec", 1'b0, 0, 1'b1, 1'b0, 1'b0, i, 1, 0);
      end
      step("t5.abst", 1'b1, 7, 1'b1, 1'b1, 1'b0, 4, 0, 0);
      step("t5.idle", 1'b0, 0, 1'b1, 1'b0, 1'b0, 4, 0, 0);
      step("t5.zst",  1'b1, 0, 1'b0, 1'b0, 1'b0, 0, 0, 1);
      step("t5.post", 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
      // restart with zero while running
      step("t5.ld3",  1'b1, 3, 1'b0, 1'b0, 1'b0, 3, 1, 0);
      step("t5.rz",   1'b1, 0, 1'b1, 1'b0, 1'b0, 0, 0, 1);

      // 6: asynchronous reset mid-count at 9
      step("t6.load", 1'b1, 12, 1'b1, 1'b0, 1'b0, 12, 1, 0);
      for (int i = 11; i >= 9; i--) begin
         step("t6.dec", 1'b0, 0, 1'b1, 1'b0, 1'b0, i, 1, 0);
      end
      @(negedge clk);
      start    = 1'b0;
      count_en = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      check_outputs("t6.arst", 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;
      step("t6.after", 1'b0, 0, 1'b1, 1'b0, 1'b0, 0, 0, 0);

      check("sb.drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
